cartoon_prep: RTL and testbench

- Streaming 3x3 neighbourhood front end that produces the `cartoon_blur` and `cartoon_edge` operands consumed by the cartoon stage.
- Input pixels are packed as H[23:16], S[15:8], V[7:0].
- Uses two line buffers and a 3x3 window to compute a 1-2-1 Gaussian blur on all three channels and a saturated Sobel magnitude on V.
- Also forwards the raw centre pixel aligned to both results.

---
 rtl/cartoon_prep.sv | 201 ++++++++++++++++++++
 tb/tb_cartoon_prep.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cartoon_prep.sv
// Streaming 3x3 front end for the cartoon stage: 1-2-1 Gaussian blur on H/S/V,
// saturated Sobel magnitude on V, and the raw centre pixel, two clocks after the trigger beat.
module cartoon_prep #(
    parameter int IMG_WIDTH = 640,
    parameter int CW        = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic [23:0] pixel_in,
    output logic        out_valid,
    output logic        out_sof,
    output logic [23:0] cartoon_blur,
    output logic [7:0]  cartoon_edge,
    output logic [23:0] pixel_out
);

    localparam int            AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

    // ------------------------------------------------------------------
    // Raster position tracking
    // ------------------------------------------------------------------
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic          sof_pend_q, sof_pend_d;
    logic [CW-1:0] pos_col;
    logic [1:0]    pos_row;
    logic          trigger;

    // Row saturates at 2, so the first trigger of a frame is tracked by sof_pend.
    always_comb begin
        pos_col    = in_sof ? '0 : col_q;
        pos_row    = in_sof ? 2'd0 : row_q;
        trigger    = in_valid && (pos_row == 2'd2) && (pos_col >= CW'(2));
        col_d      = col_q;
        row_d      = row_q;
        sof_pend_d = sof_pend_q;
        if (in_valid) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == 2'd2) ? 2'd2 : pos_row + 2'd1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end
            if (in_sof) begin
                sof_pend_d = 1'b1;
            end
            if (trigger) begin
                sof_pend_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and 3x3 window
    // ------------------------------------------------------------------
    logic [23:0]   lb0_mem [IMG_WIDTH];
    logic [23:0]   lb1_mem [IMG_WIDTH];
    logic [AW-1:0] lb_addr;
    logic [23:0]   lb0_rd;
    logic [23:0]   lb1_rd;
    logic [23:0]   win_q [3][3];

    assign lb_addr = pos_col[AW-1:0];
    assign lb0_rd  = lb0_mem[lb_addr];
    assign lb1_rd  = lb1_mem[lb_addr];

    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1_mem[lb_addr] <= lb0_rd;
            lb0_mem[lb_addr] <= pixel_in;
        end
    end

    // Column 2 is the newest; rows run oldest (0) to newest (2).
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= win_q[i][2];
            end
            win_q[0][2] <= lb1_rd;
            win_q[1][2] <= lb0_rd;
            win_q[2][2] <= pixel_in;
        end
    end

    // ------------------------------------------------------------------
    // Control pipeline
    // ------------------------------------------------------------------
    logic v0_q, s0_q;
    logic v1_q, s1_q;
    logic out_valid_q, out_sof_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= 2'd0;
            sof_pend_q  <= 1'b1;
            v0_q        <= 1'b0;
            s0_q        <= 1'b0;
            v1_q        <= 1'b0;
            s1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            sof_pend_q  <= sof_pend_d;
            v0_q        <= trigger;
            s0_q        <= trigger && sof_pend_q;
            v1_q        <= v0_q;
            s1_q        <= s0_q;
            out_valid_q <= v1_q;
            out_sof_q   <= s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: blur sums and signed gradients from the window
    // ------------------------------------------------------------------
    function automatic logic [11:0] tap(input logic [23:0] p, input int ch);
        return {4'd0, p[ch*8 +: 8]};
    endfunction

    logic [11:0] bsum [3];
    logic [23:0] blur_d;
    logic [11:0] gx_d, gy_d;

    always_comb begin
        blur_d = '0;
        for (int ch = 0; ch < 3; ch++) begin
            bsum[ch] = tap(win_q[0][0], ch) + tap(win_q[0][2], ch)
                     + tap(win_q[2][0], ch) + tap(win_q[2][2], ch)
                     + ((tap(win_q[0][1], ch) + tap(win_q[1][0], ch)
                       + tap(win_q[1][2], ch) + tap(win_q[2][1], ch)) << 1)
                     + (tap(win_q[1][1], ch) << 2);
            blur_d[ch*8 +: 8] = 8'(bsum[ch] >> 4);
        end
    end

    // Gradients fit in 12-bit two's complement (|G| <= 1020).
    always_comb begin
        gx_d = (tap(win_q[0][2], 0) + (tap(win_q[1][2], 0) << 1) + tap(win_q[2][2], 0))
             - (tap(win_q[0][0], 0) + (tap(win_q[1][0], 0) << 1) + tap(win_q[2][0], 0));
        gy_d = (tap(win_q[2][0], 0) + (tap(win_q[2][1], 0) << 1) + tap(win_q[2][2], 0))
             - (tap(win_q[0][0], 0) + (tap(win_q[0][1], 0) << 1) + tap(win_q[0][2], 0));
    end

    logic [23:0] blur1_q;
    logic [11:0] gx_q, gy_q;
    logic [23:0] ctr1_q;

    always_ff @(posedge clk) begin
        if (v0_q) begin
            blur1_q <= blur_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            ctr1_q  <= win_q[1][1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude, saturation and output registers
    // ------------------------------------------------------------------
    logic [11:0] ax, ay, mag;
    logic [7:0]  edge_d;

    always_comb begin
        ax     = gx_q[11] ? (12'd0 - gx_q) : gx_q;
        ay     = gy_q[11] ? (12'd0 - gy_q) : gy_q;
        mag    = ax + ay;
        edge_d = (mag > 12'd255) ? 8'hFF : mag[7:0];
    end

    logic [23:0] blur_q;
    logic [7:0]  edge_q;
    logic [23:0] pix_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blur_q <= '0;
            edge_q <= '0;
            pix_q  <= '0;
        end else if (v1_q) begin
            blur_q <= blur1_q;
            edge_q <= edge_d;
            pix_q  <= ctr1_q;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sof      = out_sof_q;
    assign cartoon_blur = blur_q;
    assign cartoon_edge = edge_q;
    assign pixel_out    = pix_q;

endmodule

// File: tb/tb_cartoon_prep.sv
// Directed bench for cartoon_prep on an 8-pixel-wide image: flat, step, impulse,
// gapped input, mid-frame in_sof and mid-frame reset.
module tb_cartoon_prep;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic [23:0] pixel_in;
    logic        out_valid;
    logic        out_sof;
    logic [23:0] cartoon_blur;
    logic [7:0]  cartoon_edge;
    logic [23:0] pixel_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cartoon_prep #(.IMG_WIDTH(W), .CW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .pixel_in     (pixel_in),
        .out_valid    (out_valid),
        .out_sof      (out_sof),
        .cartoon_blur (cartoon_blur),
        .cartoon_edge (cartoon_edge),
        .pixel_out    (pixel_out)
    );

    // ---------------- clock / cycle stamp ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- output monitor ----------------
    typedef struct {
        logic [23:0] blur;
        logic [7:0]  edg;
        logic [23:0] pix;
        logic        sof;
        int          cyc;
    } out_t;

    out_t         got_q[$];
    out_t         mon_o;
    int           trig_q[$];
    logic [56:0]  exp_q[$];

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            mon_o.blur = cartoon_blur;
            mon_o.edg  = cartoon_edge;
            mon_o.pix  = pixel_out;
            mon_o.sof  = out_sof;
            mon_o.cyc  = cyc;
            got_q.push_back(mon_o);
        end
    end

    // ---------------- stimulus images and hand-derived results ----------------
    function automatic logic [23:0] pix_of(input int kind, input int r, input int c);
        case (kind)
            0:       return 24'h405080;
            1:       return (c >= 4) ? 24'h0000FF : 24'h000000;
            default: return (r == 3 && c == 3) ? 24'h0000FF : 24'h000000;
        endcase
    endfunction

    // {blur, edge, pixel_out} for the output centred at (r, c)
    function automatic logic [55:0] exp_data(input int kind, input int r, input int c);
        logic [7:0] bv, ev, pv;
        int dr, dc;
        bv = 8'h00; ev = 8'h00; pv = 8'h00;
        dr = (r > 3) ? r - 3 : 3 - r;
        dc = (c > 3) ? c - 3 : 3 - c;
        if (kind == 0) return {24'h405080, 8'h00, 24'h405080};
        if (kind == 1) begin
            case (c)
                3:       bv = 8'h3F;
                4:       bv = 8'hBF;
                5, 6:    bv = 8'hFF;
                default: bv = 8'h00;
            endcase
            ev = (c == 3 || c == 4) ? 8'hFF : 8'h00;
            pv = (c >= 4) ? 8'hFF : 8'h00;
        end else begin
            if (dr == 0 && dc == 0) begin
                bv = 8'h3F; ev = 8'h00; pv = 8'hFF;
            end else if (dr + dc == 1) begin
                bv = 8'h1F; ev = 8'hFF;
            end else if (dr == 1 && dc == 1) begin
                bv = 8'h0F; ev = 8'hFF;
            end
        end
        return {16'h0, bv, ev, 16'h0, pv};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beats(input int kind, input int n, input bit gapped, input bit first_sof);
        int r, c;
        for (int i = 0; i < n; i++) begin
            r = i / W;
            c = i % W;
            in_valid = 1'b1;
            in_sof   = (i == 0) && first_sof;
            pixel_in = pix_of(kind, r, c);
            @(posedge clk);
            #1;
            if (r >= 2 && c >= 2) trig_q.push_back(cyc);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            if (gapped) idle(2);
        end
    endtask

    task automatic clear_sb();
        got_q.delete();
        trig_q.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_sof !== 1'b0) begin errors++; $display("FAIL reset_sof got %b want 0", out_sof); end
        checks++; if (cartoon_blur !== 24'h0) begin errors++; $display("FAIL reset_blur got %h want 000000", cartoon_blur); end
        checks++; if (cartoon_edge !== 8'h0) begin errors++; $display("FAIL reset_edge got %h want 00", cartoon_edge); end
        checks++; if (pixel_out !== 24'h0) begin errors++; $display("FAIL reset_pix got %h want 000000", pixel_out); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL reset_pulses got %0d want 0", got_q.size()); end
    endtask

    task automatic test_flat();
        for (int g = 0; g < 2; g++) begin
            clear_sb();
            for (int k = 0; k < (W - 2) * 4; k++)
                exp_q.push_back({k == 0, exp_data(0, 1 + k / (W - 2), 1 + k % (W - 2))});
            send_beats(0, 6 * W, g[0], 1'b1);
            idle(4);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL flat_count gap=%0d got %0d want %0d", g, got_q.size(), exp_q.size());
            end
            foreach (exp_q[k]) if (k < got_q.size()) begin
                checks++;
                if ({got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix} !== exp_q[k]) begin
                    errors++; $display("FAIL flat_data gap=%0d #%0d got %h want %h", g, k,
                        {got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix}, exp_q[k]);
                end
                checks++;
                if (got_q[k].cyc !== trig_q[k] + 2) begin
                    errors++; $display("FAIL flat_latency gap=%0d #%0d got %0d want %0d", g, k, got_q[k].cyc, trig_q[k] + 2);
                end
            end
        end
    endtask

    task automatic test_step();
        for (int g = 0; g < 2; g++) begin
            clear_sb();
            for (int k = 0; k < (W - 2) * 4; k++)
                exp_q.push_back({k == 0, exp_data(1, 1 + k / (W - 2), 1 + k % (W - 2))});
            send_beats(1, 6 * W, g[0], 1'b1);
            idle(4);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL step_count gap=%0d got %0d want %0d", g, got_q.size(), exp_q.size());
            end
            foreach (exp_q[k]) if (k < got_q.size()) begin
                checks++;
                if ({got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix} !== exp_q[k]) begin
                    errors++; $display("FAIL step_data gap=%0d #%0d got %h want %h", g, k,
                        {got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix}, exp_q[k]);
                end
                checks++;
                if (got_q[k].cyc !== trig_q[k] + 2) begin
                    errors++; $display("FAIL step_latency gap=%0d #%0d got %0d want %0d", g, k, got_q[k].cyc, trig_q[k] + 2);
                end
            end
        end
    endtask

    task automatic test_impulse();
        clear_sb();
        for (int k = 0; k < (W - 2) * 4; k++)
            exp_q.push_back({k == 0, exp_data(2, 1 + k / (W - 2), 1 + k % (W - 2))});
        send_beats(2, 6 * W, 1'b0, 1'b1);
        idle(4);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL impulse_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            checks++;
            if ({got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix} !== exp_q[k]) begin
                errors++; $display("FAIL impulse_data #%0d got %h want %h", k,
                    {got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix}, exp_q[k]);
            end
            checks++;
            if (got_q[k].cyc !== trig_q[k] + 2) begin
                errors++; $display("FAIL impulse_latency #%0d got %0d want %0d", k, got_q[k].cyc, trig_q[k] + 2);
            end
        end
    endtask

    // Flat frame cut at (3,5) by in_sof, immediately followed by a 4-row step frame.
    task automatic test_mid_sof();
        clear_sb();
        for (int k = 0; k < 9; k++)
            exp_q.push_back({k == 0, exp_data(0, 1 + k / (W - 2), 1 + k % (W - 2))});
        for (int k = 0; k < (W - 2) * 2; k++)
            exp_q.push_back({k == 0, exp_data(1, 1 + k / (W - 2), 1 + k % (W - 2))});
        send_beats(0, 3 * W + 5, 1'b0, 1'b1);
        send_beats(1, 4 * W, 1'b0, 1'b1);
        idle(4);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midsof_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            checks++;
            if ({got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix} !== exp_q[k]) begin
                errors++; $display("FAIL midsof_data #%0d got %h want %h", k,
                    {got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix}, exp_q[k]);
            end
            checks++;
            if (got_q[k].cyc !== trig_q[k] + 2) begin
                errors++; $display("FAIL midsof_latency #%0d got %0d want %0d", k, got_q[k].cyc, trig_q[k] + 2);
            end
        end
    endtask

    // Reset right after beat (3,3); restart without in_sof must begin at (0,0).
    task automatic test_mid_reset();
        clear_sb();
        for (int k = 0; k < W - 2; k++)
            exp_q.push_back({k == 0, exp_data(0, 1, 1 + k)});
        send_beats(0, 3 * W + 4, 1'b0, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        checks++; if (cartoon_blur !== 24'h0) begin errors++; $display("FAIL midrst_blur got %h want 000000", cartoon_blur); end
        checks++; if (pixel_out !== 24'h0) begin errors++; $display("FAIL midrst_pix got %h want 000000", pixel_out); end
        idle(4);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midrst_pre_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            checks++;
            if ({got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix} !== exp_q[k]) begin
                errors++; $display("FAIL midrst_pre_data #%0d got %h want %h", k,
                    {got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix}, exp_q[k]);
            end
        end
        clear_sb();
        for (int k = 0; k < (W - 2) * 2; k++)
            exp_q.push_back({k == 0, exp_data(1, 1 + k / (W - 2), 1 + k % (W - 2))});
        send_beats(1, 4 * W, 1'b0, 1'b0);
        idle(4);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midrst_post_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < got_q.size()) begin
            checks++;
            if ({got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix} !== exp_q[k]) begin
                errors++; $display("FAIL midrst_post_data #%0d got %h want %h", k,
                    {got_q[k].sof, got_q[k].blur, got_q[k].edg, got_q[k].pix}, exp_q[k]);
            end
            checks++;
            if (got_q[k].cyc !== trig_q[k] + 2) begin
                errors++; $display("FAIL midrst_post_latency #%0d got %0d want %0d", k, got_q[k].cyc, trig_q[k] + 2);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        pixel_in = 24'h0;
        test_reset();
        test_flat();
        test_step();
        test_impulse();
        test_mid_sof();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
